// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller between the MEM pipe stage and the data-memory bus.
//
// Stores go into a single-entry posted write buffer and normally complete with no
// stall. Loads drain the buffer first, which keeps memory ordering intact, and then
// issue a read. memReady low freezes the pipeline.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   exmem_memread       load in MEM stage (wins over exmem_memwrite)
//   exmem_memwrite      store in MEM stage
//   exmem_addr          byte address of the access
//   exmem_wdata/_wstrb  lane-aligned store data and byte enables
//   memReady            access complete / accepted; 0 stalls the pipeline
//   rdata               registered load data, held until the next load ack
//   bus_req/_we         bus request, 1 = write
//   bus_addr            word-aligned bus address
//   bus_wdata/_wstrb    bus write data and byte enables
//   bus_ack             one-cycle completion, ignored while bus_req = 0
//   bus_rdata           read data, valid with bus_ack
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exmem_memread,
  input  logic                  exmem_memwrite,
  input  logic [ADDR_W-1:0]     exmem_addr,
  input  logic [DATA_W-1:0]     exmem_wdata,
  input  logic [DATA_W/8-1:0]   exmem_wstrb,
  output logic                  memReady,
  output logic [DATA_W-1:0]     rdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Masking keeps every address bit in use while forcing word alignment.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StRdDone
  } state_e;

  state_e              state_q, state_d;
  logic                wb_valid_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic [STRB_W-1:0]   wb_strb_q;
  logic [DATA_W-1:0]   rdata_q;

  logic is_load;
  logic is_store;
  logic wb_fill;
  logic wb_drain;
  logic rd_capture;

  assign is_load    = exmem_memread;
  assign is_store   = exmem_memwrite & ~exmem_memread;
  // Fill only into an empty buffer and drain only a full one, so both never
  // happen on the same edge.
  assign wb_fill    = is_store & ~wb_valid_q;
  assign wb_drain   = (state_q == StWr) & bus_ack;
  assign rd_capture = (state_q == StRd) & bus_ack;

  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    unique case (state_q)
      StIdle: begin
        // A store captured this edge is drained right away so bus_req rises
        // in the cycle after the store.
        if (wb_valid_q || wb_fill) begin
          state_d = StWr;
        end else if (is_load) begin
          state_d = StRd;
        end
      end
      StWr: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = wb_addr_q;
        bus_wdata = wb_data_q;
        bus_wstrb = wb_strb_q;
        if (bus_ack) begin
          state_d = is_load ? StRd : StIdle;
        end
      end
      StRd: begin
        bus_req  = 1'b1;
        bus_addr = exmem_addr & ALIGN_MASK;
        if (bus_ack) begin
          state_d = StRdDone;
        end
      end
      StRdDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    if (exmem_memread) begin
      memReady = (state_q == StRdDone);
    end else if (exmem_memwrite) begin
      memReady = ~wb_valid_q;
    end else begin
      memReady = 1'b1;
    end
  end

  assign rdata = rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_strb_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (wb_fill) begin
        wb_valid_q <= 1'b1;
        wb_addr_q  <= exmem_addr & ALIGN_MASK;
        wb_data_q  <= exmem_wdata;
        wb_strb_q  <= exmem_wstrb;
      end else if (wb_drain) begin
        wb_valid_q <= 1'b0;
      end
      if (rd_capture) begin
        rdata_q <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic [31:0] exmem_addr;
  logic [31:0] exmem_wdata;
  logic [3:0]  exmem_wstrb;
  logic        memReady;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  dmem_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .exmem_memread  (exmem_memread),
    .exmem_memwrite (exmem_memwrite),
    .exmem_addr     (exmem_addr),
    .exmem_wdata    (exmem_wdata),
    .exmem_wstrb    (exmem_wstrb),
    .memReady       (memReady),
    .rdata          (rdata),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Move to just after the next rising edge, where new inputs are driven.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic no_access();
    exmem_memread  = 1'b0;
    exmem_memwrite = 1'b0;
    bus_ack        = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    exmem_memread  = 1'b0;
    exmem_memwrite = 1'b0;
    exmem_addr     = '0;
    exmem_wdata    = '0;
    exmem_wstrb    = '0;
    bus_ack        = 1'b0;
    bus_rdata      = '0;

    // Reset state
    step();
    sample();
    check_eq("rst_req", bus_req, 1'b0);
    check_eq("rst_we", bus_we, 1'b0);
    check_eq("rst_addr", bus_addr, 32'h0);
    check_eq("rst_wdata", bus_wdata, 32'h0);
    check_eq("rst_rdy", memReady, 1'b1);
    check_eq("rst_rdata", rdata, 32'h0);
    step();
    reset = 1'b0;
    sample();
    check_eq("post_rst_rdy", memReady, 1'b1);

    // Load 0x100, ack on the 2nd request cycle
    step();
    exmem_memread = 1'b1;
    exmem_addr    = 32'h100;
    sample();
    check_eq("ld_c0_rdy", memReady, 1'b0);
    check_eq("ld_c0_req", bus_req, 1'b0);
    step();
    sample();
    check_eq("ld_c1_rdy", memReady, 1'b0);
    check_eq("ld_c1_req", bus_req, 1'b1);
    check_eq("ld_c1_we", bus_we, 1'b0);
    check_eq("ld_c1_addr", bus_addr, 32'h100);
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    sample();
    check_eq("ld_c2_rdy", memReady, 1'b0);
    check_eq("ld_c2_req", bus_req, 1'b1);
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    sample();
    check_eq("ld_c3_rdy", memReady, 1'b1);
    check_eq("ld_c3_rdata", rdata, 32'hDEADBEEF);
    check_eq("ld_c3_req", bus_req, 1'b0);
    step();
    no_access();
    sample();
    check_eq("ld_after_req", bus_req, 1'b0);
    check_eq("ld_hold_rdata", rdata, 32'hDEADBEEF);

    // Posted store to 0x206, ack in the first request cycle
    step();
    exmem_memwrite = 1'b1;
    exmem_addr     = 32'h206;
    exmem_wdata    = 32'h11223344;
    exmem_wstrb    = 4'hF;
    sample();
    check_eq("st_rdy", memReady, 1'b1);
    step();
    no_access();
    bus_ack = 1'b1;
    sample();
    check_eq("st_req", bus_req, 1'b1);
    check_eq("st_we", bus_we, 1'b1);
    check_eq("st_addr", bus_addr, 32'h204);
    check_eq("st_wdata", bus_wdata, 32'h11223344);
    check_eq("st_wstrb", bus_wstrb, 4'hF);
    check_eq("st_bus_rdy", memReady, 1'b1);
    step();
    bus_ack = 1'b0;
    sample();
    check_eq("st_done_req", bus_req, 1'b0);

    // Back-to-back stores, first write acked on its 4th request cycle
    step();
    exmem_memwrite = 1'b1;
    exmem_addr     = 32'h400;
    exmem_wdata    = 32'hA5A5_0001;
    exmem_wstrb    = 4'h3;
    sample();
    check_eq("bb_st1_rdy", memReady, 1'b1);
    step();
    exmem_addr  = 32'h408;
    exmem_wdata = 32'h5A5A_0002;
    exmem_wstrb = 4'hC;
    for (int i = 0; i < 4; i++) begin
      bus_ack = (i == 3);
      sample();
      check_eq("bb_stall_rdy", memReady, 1'b0);
      check_eq("bb_w1_addr", bus_addr, 32'h400);
      check_eq("bb_w1_wdata", bus_wdata, 32'hA5A5_0001);
      step();
    end
    bus_ack = 1'b0;
    sample();
    check_eq("bb_st2_rdy", memReady, 1'b1);
    check_eq("bb_gap_req", bus_req, 1'b0);
    step();
    no_access();
    bus_ack = 1'b1;
    sample();
    check_eq("bb_w2_req", bus_req, 1'b1);
    check_eq("bb_w2_we", bus_we, 1'b1);
    check_eq("bb_w2_addr", bus_addr, 32'h408);
    check_eq("bb_w2_wdata", bus_wdata, 32'h5A5A_0002);
    check_eq("bb_w2_wstrb", bus_wstrb, 4'hC);
    step();
    bus_ack = 1'b0;
    sample();
    check_eq("bb_end_req", bus_req, 1'b0);

    // Store then load at 0x300: write, then read with no gap
    step();
    exmem_memwrite = 1'b1;
    exmem_addr     = 32'h300;
    exmem_wdata    = 32'h0000_BEEF;
    exmem_wstrb    = 4'hF;
    sample();
    check_eq("sl_st_rdy", memReady, 1'b1);
    step();
    exmem_memwrite = 1'b0;
    exmem_memread  = 1'b1;
    bus_ack        = 1'b1;
    sample();
    check_eq("sl_wr_req", bus_req, 1'b1);
    check_eq("sl_wr_we", bus_we, 1'b1);
    check_eq("sl_wr_addr", bus_addr, 32'h300);
    check_eq("sl_wr_rdy", memReady, 1'b0);
    step();
    bus_rdata = 32'hCAFEF00D;
    sample();
    check_eq("sl_rd_req", bus_req, 1'b1);
    check_eq("sl_rd_we", bus_we, 1'b0);
    check_eq("sl_rd_addr", bus_addr, 32'h300);
    check_eq("sl_rd_rdy", memReady, 1'b0);
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    sample();
    check_eq("sl_done_rdy", memReady, 1'b1);
    check_eq("sl_rdata", rdata, 32'hCAFEF00D);
    step();
    no_access();

    // Load and store both high: treated as a load, no write issued
    exmem_memread  = 1'b1;
    exmem_memwrite = 1'b1;
    exmem_addr     = 32'h700;
    exmem_wdata    = 32'hFFFF_FFFF;
    sample();
    check_eq("both_c0_rdy", memReady, 1'b0);
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BADF00D;
    sample();
    check_eq("both_req", bus_req, 1'b1);
    check_eq("both_we", bus_we, 1'b0);
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    sample();
    check_eq("both_rdy", memReady, 1'b1);
    check_eq("both_rdata", rdata, 32'h0BADF00D);
    step();
    no_access();
    for (int i = 0; i < 2; i++) begin
      sample();
      check_eq("both_no_wr", bus_req, 1'b0);
      step();
    end

    // Reset while a read is in flight and the buffer holds a store
    exmem_memread = 1'b1;
    exmem_addr    = 32'h500;
    step();
    exmem_memread  = 1'b0;
    exmem_memwrite = 1'b1;
    exmem_addr     = 32'h600;
    exmem_wdata    = 32'h7777_7777;
    sample();
    check_eq("rr_rd_req", bus_req, 1'b1);
    check_eq("rr_st_rdy", memReady, 1'b1);
    step();
    exmem_memwrite = 1'b0;
    exmem_memread  = 1'b1;
    exmem_addr     = 32'h500;
    reset          = 1'b1;
    sample();
    check_eq("rr_pre_req", bus_req, 1'b1);
    check_eq("rr_pre_we", bus_we, 1'b0);
    check_eq("rr_pre_rdy", memReady, 1'b0);
    step();
    reset = 1'b0;
    no_access();
    sample();
    check_eq("rr_req", bus_req, 1'b0);
    check_eq("rr_rdata", rdata, 32'h0);
    check_eq("rr_rdy", memReady, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      check_eq("rr_no_wr", bus_req, 1'b0);
    end

    // Idle for 10 cycles with stray acks
    for (int i = 0; i < 10; i++) begin
      step();
      no_access();
      bus_ack = i[0];
      sample();
      check_eq("idle_rdy", memReady, 1'b1);
      check_eq("idle_req", bus_req, 1'b0);
    end
    step();
    bus_ack = 1'b0;
    sample();
    check_eq("idle_rdata", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
